// File: rtl/hilo_md_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hilo_md_ctrl
// Purpose  : Multiply/divide sequencer for the 5-stage pipeline. Owns the
//            HI/LO registers, accepts md ops from the E stage, counts the
//            fixed mult/div latency and raises the stall that freezes F/D
//            while HI/LO is busy.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   MULT_CYCLES   busy cycles for mult/multu (1..15)
//   DIV_CYCLES    busy cycles for div/divu   (1..15)
// Ports:
//   clk           in   1   pipeline clock, rising edge
//   reset         in   1   asynchronous, active-high reset
//   E_md_op       in   4   E-stage op: 0 none, 1 mult, 2 multu, 3 div,
//                          4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo,
//                          9..15 treated as none
//   E_rs          in  32   forwarded rs operand in E
//   E_rt          in  32   forwarded rt operand in E
//   D_is_md       in   1   D-stage instruction is an md op
//   busy          out  1   mult/div in progress (registered)
//   start         out  1   mult/div accepted this cycle (combinational)
//   md_stall      out  1   stall request to the hazard unit (combinational)
//   E_HILOResult  out 32   mfhi/mflo read data (combinational)
//   HI            out 32   HI register
//   LO            out 32   LO register
// ============================================================================
module hilo_md_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_md_op,
    input  logic [31:0] E_rs,
    input  logic [31:0] E_rt,
    input  logic        D_is_md,
    output logic        busy,
    output logic        start,
    output logic        md_stall,
    output logic [31:0] E_HILOResult,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    // ------------------------------------------------------------------------
    // Op encodings and constants
    // ------------------------------------------------------------------------
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]  state_q,      state_d;
    logic [3:0]  count_q,      count_d;
    logic [31:0] hi_q,         hi_d;
    logic [31:0] lo_q,         lo_d;
    logic [31:0] pending_hi_q, pending_hi_d;
    logic [31:0] pending_lo_q, pending_lo_d;
    // Cleared for a divide by zero so completion leaves HI/LO untouched.
    logic        pending_wr_q, pending_wr_d;

    // ------------------------------------------------------------------------
    // Op decode
    // ------------------------------------------------------------------------
    logic is_mult;
    logic is_div;
    logic is_signed;

    assign is_mult   = (E_md_op == OP_MULT) || (E_md_op == OP_MULTU);
    assign is_div    = (E_md_op == OP_DIV)  || (E_md_op == OP_DIVU);
    assign is_signed = (E_md_op == OP_MULT) || (E_md_op == OP_DIV);

    // ------------------------------------------------------------------------
    // Multiplier: extend both operands to 64 bits per signedness. The low
    // 64 bits of a two's-complement product are the same for signed and
    // unsigned arithmetic once the operands are correctly extended.
    // ------------------------------------------------------------------------
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] mul_prod;

    assign mul_a    = {{32{is_signed & E_rs[31]}}, E_rs};
    assign mul_b    = {{32{is_signed & E_rt[31]}}, E_rt};
    assign mul_prod = mul_a * mul_b;

    // ------------------------------------------------------------------------
    // Divider: divide magnitudes unsigned, then restore signs. This gives
    // truncation toward zero with the remainder following the dividend, and
    // makes 0x80000000 / -1 land naturally on LO=0x80000000, HI=0 with no
    // signed-overflow corner. A zero divisor is replaced by 1 to keep the
    // datapath well-defined; its result is never committed.
    // ------------------------------------------------------------------------
    logic        rs_neg;
    logic        rt_neg;
    logic        div_by_zero;
    logic [31:0] abs_rs;
    logic [31:0] abs_rt;
    logic [31:0] divisor;
    logic [31:0] uquot;
    logic [31:0] urem;
    logic [31:0] quot;
    logic [31:0] rem;

    assign rs_neg      = is_signed & E_rs[31];
    assign rt_neg      = is_signed & E_rt[31];
    assign div_by_zero = (E_rt == 32'd0);
    assign abs_rs      = rs_neg ? (~E_rs + 32'd1) : E_rs;
    assign abs_rt      = rt_neg ? (~E_rt + 32'd1) : E_rt;
    assign divisor     = div_by_zero ? 32'd1 : abs_rt;
    assign uquot       = abs_rs / divisor;
    assign urem        = abs_rs % divisor;
    assign quot        = (rs_neg ^ rt_neg) ? (~uquot + 32'd1) : uquot;
    assign rem         = rs_neg ? (~urem + 32'd1) : urem;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        pending_hi_d = pending_hi_q;
        pending_lo_d = pending_lo_q;
        pending_wr_d = pending_wr_q;
        start        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (is_mult || is_div) begin
                    start        = 1'b1;
                    state_d      = S_BUSY;
                    count_d      = is_mult ? MULT_CNT : DIV_CNT;
                    pending_wr_d = is_mult | ~div_by_zero;
                    if (is_mult) begin
                        pending_hi_d = mul_prod[63:32];
                        pending_lo_d = mul_prod[31:0];
                    end else begin
                        pending_hi_d = rem;
                        pending_lo_d = quot;
                    end
                end else if (E_md_op == OP_MTHI) begin
                    hi_d = E_rs;
                end else if (E_md_op == OP_MTLO) begin
                    lo_d = E_rs;
                end
            end
            S_BUSY: begin
                // Any E-stage op seen here can only be forced; it is ignored.
                if (count_q == 4'd1) begin
                    if (pending_wr_q) begin
                        hi_d = pending_hi_q;
                        lo_d = pending_lo_q;
                    end
                    count_d = 4'd0;
                    state_d = S_IDLE;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            count_q      <= 4'd0;
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
            pending_hi_q <= 32'd0;
            pending_lo_q <= 32'd0;
            pending_wr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            pending_hi_q <= pending_hi_d;
            pending_lo_q <= pending_lo_d;
            pending_wr_q <= pending_wr_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign busy     = (state_q == S_BUSY);
    assign HI       = hi_q;
    assign LO       = lo_q;

    // Only md ops in D are held back; the start term covers the accept cycle
    // before busy is registered.
    assign md_stall = D_is_md & (start | busy);

    always_comb begin
        case (E_md_op)
            OP_MFHI: E_HILOResult = hi_q;
            OP_MFLO: E_HILOResult = lo_q;
            default: E_HILOResult = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_hilo_md_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hilo_md_ctrl
// Purpose  : Directed self-checking bench for hilo_md_ctrl with
//            hand-computed expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hilo_md_ctrl;

    logic        clk;
    logic        reset;
    logic [3:0]  E_md_op;
    logic [31:0] E_rs;
    logic [31:0] E_rt;
    logic        D_is_md;
    logic        busy;
    logic        start;
    logic        md_stall;
    logic [31:0] E_HILOResult;
    logic [31:0] HI;
    logic [31:0] LO;

    int vectors;
    int miscompares;

    hilo_md_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .E_md_op      (E_md_op),
        .E_rs         (E_rs),
        .E_rt         (E_rt),
        .D_is_md      (D_is_md),
        .busy         (busy),
        .start        (start),
        .md_stall     (md_stall),
        .E_HILOResult (E_HILOResult),
        .HI           (HI),
        .LO           (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Cycle boundary: inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic dmd);
        E_md_op = op;
        E_rs    = rs;
        E_rt    = rt;
        D_is_md = dmd;
    endtask

    // Issue a mult/div in the next cycle, check busy for exactly n cycles
    // and the committed HI/LO in cycle T+n+1.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] rs, input logic [31:0] rt,
                          input int n, input logic [31:0] ehi, input logic [31:0] elo);
        tick();
        drive(op, rs, rt, 1'b0);
        #1;
        chk({tag, "_start"}, 32'(start), 32'd1);
        for (int i = 1; i <= n; i++) begin
            tick();
            drive(4'd0, 32'd0, 32'd0, 1'b0);
            #1;
            chk({tag, "_busy"}, 32'(busy), 32'd1);
        end
        tick();
        #1;
        chk({tag, "_done"}, 32'(busy), 32'd0);
        chk({tag, "_hi"}, HI, ehi);
        chk({tag, "_lo"}, LO, elo);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        drive(4'd0, 32'd0, 32'd0, 1'b1);

        // Reset state before any clock edge.
        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_stall", 32'(md_stall), 32'd0);
        #4;
        reset = 1'b0;
        D_is_md = 1'b0;

        // Signed mult: -2 * 3 = -6.
        run_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        // Signed div with an md op waiting in D: -7 / 2 = -3 rem -1.
        tick();
        drive(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1);
        #1;
        chk("div_start", 32'(start), 32'd1);
        chk("div_stall0", 32'(md_stall), 32'd1);
        for (int i = 1; i <= 10; i++) begin
            tick();
            drive(4'd0, 32'd0, 32'd0, 1'b1);
            #1;
            chk("div_stall", 32'(md_stall), 32'd1);
        end
        tick();
        #1;
        chk("div_release", 32'(md_stall), 32'd0);
        chk("div_lo", LO, 32'hFFFF_FFFD);
        chk("div_hi", HI, 32'hFFFF_FFFF);
        tick();
        drive(4'd8, 32'd0, 32'd0, 1'b0);
        #1;
        chk("div_mflo", E_HILOResult, 32'hFFFF_FFFD);

        // Divide by zero keeps HI/LO but still takes the full latency.
        tick();
        drive(4'd5, 32'h11, 32'd0, 1'b0);
        tick();
        drive(4'd6, 32'h22, 32'd0, 1'b0);
        tick();
        drive(4'd0, 32'd0, 32'd0, 1'b0);
        #1;
        chk("mt_hi", HI, 32'h11);
        chk("mt_lo", LO, 32'h22);
        run_op("divz", 4'd4, 32'd5, 32'd0, 10, 32'h11, 32'h22);

        // Arithmetic corners.
        run_op("ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);
        run_op("divu", 4'd4, 32'hFFFF_FFFF, 32'd10, 10, 32'd5, 32'h1999_9999);
        run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("sdivp", 4'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);

        // mthi then mfhi back-to-back, no stall.
        tick();
        drive(4'd5, 32'hABCD, 32'd0, 1'b1);
        #1;
        chk("mthi_stall", 32'(md_stall), 32'd0);
        tick();
        drive(4'd7, 32'd0, 32'd0, 1'b0);
        #1;
        chk("mfhi_data", E_HILOResult, 32'hABCD);
        chk("mfhi_stall", 32'(md_stall), 32'd0);

        // Non-md instruction in D while busy is never stalled.
        tick();
        drive(4'd1, 32'd2, 32'd3, 1'b0);
        #1;
        chk("nonmd_start_stall", 32'(md_stall), 32'd0);
        tick();
        drive(4'd0, 32'd0, 32'd0, 1'b0);
        #1;
        chk("nonmd_busy", 32'(busy), 32'd1);
        chk("nonmd_stall", 32'(md_stall), 32'd0);
        for (int i = 2; i <= 5; i++) tick();
        tick();
        #1;
        chk("nonmd_hi", HI, 32'd0);
        chk("nonmd_lo", LO, 32'd6);

        // Reset during busy cycle 3 of a multu discards the result.
        tick();
        drive(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        tick();
        drive(4'd0, 32'd0, 32'd0, 1'b0);
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_hi", HI, 32'd0);
        chk("midrst_lo", LO, 32'd0);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            #1;
            chk("postrst_lo", LO, 32'd0);
        end
        run_op("postrst", 4'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hilo_md_ctrl.md
Name: hilo_md_ctrl

Overview:
- Multiply/divide sequencer for the 5-stage pipeline. Owns the HI/LO registers and accepts mult/multu/div/divu/mthi/mtlo/mfhi/mflo from the E stage.
- Counts the fixed multi-cycle latency of mult/div operations and drives the stall that freezes F/D and bubbles E while HI/LO is busy.
- Supplies E_HILOResult, which is registered into the EX/MEM pipeline register.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high reset
- E_md_op  in  4  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; values 9..15 are treated as none
- E_rs  in  32  forwarded rs operand in E
- E_rt  in  32  forwarded rt operand in E
- D_is_md  in  1  D-stage instruction is any md op (codes 1..8)
- busy  out  1  mult/div in progress
- start  out  1  combinational; high in the cycle a mult/div op is accepted
- md_stall  out  1  combinational stall request to the hazard unit
- E_HILOResult  out  32  combinational mfhi/mflo read data
- HI  out  32  HI register
- LO  out  32  LO register

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous and active-high and wins over everything.
- Reset values: HI=0, LO=0, busy=0, count=0, pending result=0, state IDLE. A reset asserted mid-operation discards the pending result, and HI/LO stay 0.
- Combinational outputs: start, md_stall and E_HILOResult are combinational; busy, HI and LO are registered.
- State IDLE (busy=0):
  - start = (E_md_op in 1..4).
  - On the start edge: compute the 64-bit result and hold it in pending_hi/pending_lo; load count with MULT_CYCLES or DIV_CYCLES; go to BUSY.
  - mthi: HI<=E_rs at the edge. mtlo: LO<=E_rs at the edge.
- State BUSY (busy=1):
  - count decrements each edge.
  - On the edge where count==1: HI<=pending_hi, LO<=pending_lo, count<=0, go to IDLE.
  - busy is therefore high for exactly N cycles following the start cycle.
- Latency: an op in E at cycle T makes HI/LO visible in cycle T+N+1.
- Arithmetic:
  - mult: signed 32x32 -> 64; multu: unsigned. HI gets bits [63:32], LO gets bits [31:0].
  - div/divu: LO = quotient, HI = remainder, truncating toward zero; the remainder takes the sign of the dividend.
  - Divisor 0: timing is unchanged (busy for DIV_CYCLES), but HI and LO keep their old values.
  - Signed 0x80000000 / -1: LO=0x80000000, HI=0.
- Stall: md_stall = D_is_md & (start | busy).
  - Consequence: no md op reaches E while busy=1, so an E op in 1..8 during BUSY cannot occur.
  - Such an op is ignored if forced.
- Read path: E_HILOResult = HI if mfhi, LO if mflo, else 0. In IDLE it reflects the current HI/LO, including an mthi/mtlo written on the previous edge.
- Simultaneous events:
  - Completion edge plus md op in D: the stall releases in the next cycle, and the op reads the new HI/LO.
  - Non-md instructions are never stalled by this block.

Test Plan:
- Reset then idle: assert reset mid-cycle (async) -> HI=LO=0, busy=0, md_stall=0 immediately, without waiting for a clock edge.
- Signed mult: E_md_op=1, rs=0xFFFFFFFE, rt=3 at T -> start=1 at T, busy=1 for T+1..T+5, HI=0xFFFFFFFF and LO=0xFFFFFFFA at T+6.
- Div with mflo in D: E_md_op=3, rs=-7, rt=2; D_is_md=1 from T onward -> md_stall=1 for T..T+10, 0 at T+11, LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then mflo in E gives E_HILOResult=0xFFFFFFFD.
- Divide by zero: HI=0x11, LO=0x22, then divu with rt=0 -> busy for 10 cycles, HI/LO stay 0x11/0x22.
- mthi/mtlo/mfhi back-to-back: mthi rs=0xABCD, next cycle mfhi -> E_HILOResult=0xABCD with no stall. Then a non-md instruction in D during BUSY -> md_stall=0.
- Reset at busy cycle 3 of a multu: busy=0 and HI=LO=0 after reset; the next mult completes normally with a full count.
